// File: rtl/traffic_pkg.sv
// Shared state encoding, light encodings, default phase durations and small helpers
// for the traffic sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    StRedB       = 3'd0,
    StMainGreen  = 3'd1,
    StMainYellow = 3'd2,
    StRedA       = 3'd3,
    StSideGreen  = 3'd4,
    StSideYellow = 3'd5,
    StWalk       = 3'd6
  } state_e;

  // {Red, Yellow, Green}
  localparam logic [2:0] LightRed    = 3'b100;
  localparam logic [2:0] LightYellow = 3'b010;
  localparam logic [2:0] LightGreen  = 3'b001;

  localparam int DefMainGreen = 8;
  localparam int DefSideGreen = 5;
  localparam int DefYellow    = 3;
  localparam int DefAllRed    = 1;
  localparam int DefWalk      = 6;

  // Durations live in a 4-bit timer load; 0 would never expire meaningfully.
  function automatic logic [3:0] clamp_dur(int d);
    if (d < 1) return 4'd1;
    if (d > 15) return 4'd15;
    return 4'(d);
  endfunction

  function automatic logic [2:0] main_light(state_e s);
    case (s)
      StMainGreen:  return LightGreen;
      StMainYellow: return LightYellow;
      default:      return LightRed;
    endcase
  endfunction

  function automatic logic [2:0] side_light(state_e s);
    case (s)
      StSideGreen:  return LightGreen;
      StSideYellow: return LightYellow;
      default:      return LightRed;
    endcase
  endfunction

endpackage

// File: rtl/traffic_sequencer_if.sv
// Sensor/timer/lamp bundle between the traffic sequencer (slave) and its environment (master).
interface traffic_sequencer_if;
  logic       Sensor;
  logic       Walk_Request;
  logic       Expired;
  logic       Start_Timer;
  logic [3:0] Value;
  logic [2:0] Main_Light;
  logic [2:0] Side_Light;
  logic       Walk_Lamp;

  modport master (
    output Sensor, Walk_Request, Expired,
    input  Start_Timer, Value, Main_Light, Side_Light, Walk_Lamp
  );

  modport slave (
    input  Sensor, Walk_Request, Expired,
    output Start_Timer, Value, Main_Light, Side_Light, Walk_Lamp
  );
endinterface

// File: rtl/demand_latch.sv
// Sticky request flag: set by a request level, cleared (with priority) when serviced.
module demand_latch (
  input  logic clk,
  input  logic Reset_n,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (set_i) q_d = 1'b1;
    if (clr_i) q_d = 1'b0;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) q_q <= 1'b0;
    else          q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/traffic_sequencer.sv
// Two-road traffic light sequencer driving an external countdown timer.
// Define TRAFFIC_WALK_EN to add the pedestrian WALK phase between RED_A and SIDE_GREEN.
module traffic_sequencer import traffic_pkg::*; #(
  parameter int T_MAIN_GREEN = DefMainGreen,
  parameter int T_SIDE_GREEN = DefSideGreen,
  parameter int T_YELLOW     = DefYellow,
  parameter int T_ALL_RED    = DefAllRed,
  parameter int T_WALK       = DefWalk
) (
  input logic                clk,
  input logic                Reset_n,
  traffic_sequencer_if.slave bus
);

  localparam logic [3:0] DurMainGreen = clamp_dur(T_MAIN_GREEN);
  localparam logic [3:0] DurSideGreen = clamp_dur(T_SIDE_GREEN);
  localparam logic [3:0] DurYellow    = clamp_dur(T_YELLOW);
  localparam logic [3:0] DurAllRed    = clamp_dur(T_ALL_RED);
  localparam logic [3:0] DurWalk      = clamp_dur(T_WALK);

  function automatic logic [3:0] dur_of(state_e s);
    case (s)
      StMainGreen:               return DurMainGreen;
      StSideGreen:               return DurSideGreen;
      StMainYellow, StSideYellow: return DurYellow;
      StWalk:                    return DurWalk;
      default:                   return DurAllRed;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic       start_dly_q;
  logic       fresh_q;
  logic [3:0] value_q, value_d;
  logic [2:0] main_q, main_d, side_q, side_d;
  logic       lamp_q, lamp_d;
  logic       adv, qual;
  logic       side_dem, side_pend, walk_pend;

  // Timer needs two cycles to clear after a load, so Expired is stale until then.
  assign qual = bus.Expired & ~start_q & ~start_dly_q & ~fresh_q;

  demand_latch u_side_dem (
    .clk     (clk),
    .Reset_n (Reset_n),
    .set_i   (bus.Sensor && (state_q != StSideGreen)),
    .clr_i   ((state_d == StSideGreen) && (state_q != StSideGreen)),
    .q_o     (side_dem)
  );
  assign side_pend = side_dem | bus.Sensor;

`ifdef TRAFFIC_WALK_EN
  logic walk_dem;

  demand_latch u_walk_dem (
    .clk     (clk),
    .Reset_n (Reset_n),
    .set_i   (bus.Walk_Request && (state_q != StWalk)),
    .clr_i   ((state_d == StWalk) && (state_q != StWalk)),
    .q_o     (walk_dem)
  );
  assign walk_pend = walk_dem | bus.Walk_Request;
`else
  assign walk_pend = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    case (state_q)
      StRedB:       begin adv = qual; state_d = StMainGreen;  end
      StMainGreen:  begin adv = qual & (side_pend | walk_pend); state_d = StMainYellow; end
      StMainYellow: begin adv = qual; state_d = StRedA;       end
      StRedA:       begin adv = qual; state_d = walk_pend ? StWalk : StSideGreen; end
      StWalk:       begin adv = qual; state_d = StSideGreen;  end
      StSideGreen:  begin adv = qual; state_d = StSideYellow; end
      StSideYellow: begin adv = qual; state_d = StRedB;       end
      default:      begin adv = 1'b1; state_d = StRedB;       end
    endcase
    if (!adv) state_d = state_q;

    // The first clock after reset is treated as an entry into RED_B.
    start_d = adv | fresh_q;
    value_d = start_d ? dur_of(state_d) : value_q;
    main_d  = main_light(state_d);
    side_d  = side_light(state_d);
    lamp_d  = (state_d == StWalk);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StRedB;
      start_q     <= 1'b0;
      start_dly_q <= 1'b0;
      fresh_q     <= 1'b1;
      value_q     <= 4'd0;
      main_q      <= LightRed;
      side_q      <= LightRed;
      lamp_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      start_dly_q <= start_q;
      fresh_q     <= 1'b0;
      value_q     <= value_d;
      main_q      <= main_d;
      side_q      <= side_d;
      lamp_q      <= lamp_d;
    end
  end

  assign bus.Start_Timer = start_q;
  assign bus.Value       = value_q;
  assign bus.Main_Light  = main_q;
  assign bus.Side_Light  = side_q;
  assign bus.Walk_Lamp   = lamp_q;

endmodule

// File: doc/traffic_sequencer.md
TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 Parameter T_MAIN_GREEN, default 8, minimum main-road green in Timer seconds.
REQ-002 Parameter T_SIDE_GREEN, default 5, side-road green in Timer seconds.
REQ-003 Parameter T_YELLOW, default 3, yellow duration for either road.
REQ-004 Parameter T_ALL_RED, default 1, all-red clearance duration.
REQ-005 Parameter T_WALK, default 6, pedestrian walk duration (used only with WALK_EN).
REQ-006 Port clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-007 Port Reset_n  input  1  asynchronous, active-low reset.
REQ-008 Port Sensor  input  1  side-road vehicle present, synchronous level.
REQ-009 Port Walk_Request  input  1  pedestrian button, synchronous level (WALK_EN only; ignored otherwise).
REQ-010 Port Expired  input  1  Timer done; level, held high until next Start_Timer.
REQ-011 Port Start_Timer  output  1  one-cycle pulse loading Value into Timer.
REQ-012 Port Value  output  4  duration for current phase; valid while Start_Timer high.
REQ-013 Port Main_Light  output  3  {Red,Yellow,Green}, one-hot.
REQ-014 Port Side_Light  output  3  {Red,Yellow,Green}, one-hot.
REQ-015 Port Walk_Lamp  output  1  pedestrian walk indicator.

Function
REQ-016 States SHALL be MAIN_GREEN, MAIN_YELLOW, RED_A, SIDE_GREEN, SIDE_YELLOW, RED_B, plus WALK when WALK_EN defined.
REQ-017 Cycle order SHALL be RED_B -> MAIN_GREEN -> MAIN_YELLOW -> RED_A -> SIDE_GREEN -> SIDE_YELLOW -> RED_B.
REQ-018 On every state entry Start_Timer SHALL pulse for exactly one cycle, Value = that state's parameter, in the first cycle in the new state.
REQ-019 Expired SHALL be ignored in the Start_Timer cycle and the following cycle (Timer clear latency).
REQ-020 Non-green states SHALL advance on the first qualified Expired high.
REQ-021 MAIN_GREEN SHALL advance only when qualified Expired high AND side demand latched; otherwise hold with no re-start.
REQ-022 Side demand SHALL latch on Sensor high in any state except SIDE_GREEN, and clear on SIDE_GREEN entry.
REQ-023 SIDE_GREEN SHALL advance on qualified Expired regardless of Sensor.
REQ-024 Lights: exactly one bit set per road every cycle; at least one road Red in every state; both Red in RED_A, RED_B, WALK.
REQ-025 Outputs SHALL be registered (Moore); light change coincides with Start_Timer pulse cycle.
REQ-026 Parameters outside 1..15 SHALL be clamped to 1 or 15 at elaboration; Value never 0.
REQ-027 Sensor and Expired rising in same cycle as MAIN_GREEN qualification SHALL advance (demand latch is combinationally OR'd with Sensor).

Reset
REQ-028 Reset_n low SHALL asynchronously force state RED_B, both lights Red (3'b100), Walk_Lamp 0, Start_Timer 0, Value 0, demand latches 0.
REQ-029 First rising clk after Reset_n deassertion SHALL pulse Start_Timer with Value = T_ALL_RED.
REQ-030 Reset asserted mid-phase SHALL abandon the phase; no partial yellow on recovery.

Configuration
REQ-031 Macro TRAFFIC_WALK_EN defined: WALK state inserted between RED_A and SIDE_GREEN only when a walk demand is latched (Walk_Request high, cleared on WALK entry); WALK drives Walk_Lamp 1, both roads Red, duration T_WALK; WALK also qualifies MAIN_GREEN exit as side demand does.
REQ-032 Macro absent: no WALK state, Walk_Request unused, Walk_Lamp tied 0.

Structure
REQ-033 Package traffic_pkg SHALL hold state enum, light encodings (RED=3'b100, YELLOW=3'b010, GREEN=3'b001) and default durations.
REQ-034 Sub-module demand_latch (set/clear/async reset) SHALL be instantiated once per request source.

Verification
REQ-035 Reset release, Expired stub 3 cycles after each Start_Timer, Sensor=0 -> RED_B, MAIN_GREEN, then hold MAIN_GREEN indefinitely, exactly 2 Start_Timer pulses (Value 1, 8).
REQ-036 Sensor pulsed 1 cycle during MAIN_GREEN, Expired later -> MAIN_YELLOW (Value 3), RED_A (1), SIDE_GREEN (5), SIDE_YELLOW (3), RED_B (1), MAIN_GREEN (8).
REQ-037 Expired held high across a Start_Timer pulse -> no state advance in the 2 masked cycles.
REQ-038 Reset_n low during SIDE_YELLOW -> both lights 3'b100 same cycle, asynchronously; release -> Value 1 pulse.
REQ-039 TRAFFIC_WALK_EN, Walk_Request pulse, Sensor=0 -> MAIN_YELLOW, RED_A, WALK (Walk_Lamp=1, Value 6), SIDE_GREEN.
REQ-040 Every cycle of all runs: assertion one-hot lights, never both roads non-Red, Start_Timer width 1.
